// File: rtl/uart_rx_line_buf.sv
// Receive-side byte FIFO for a UART with CR-terminated line tracking.
// Optional build macro: RXB_ESC_FILTER_EN drops 8'h1B bytes before they reach the FIFO.
module uart_rx_line_buf #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            bu_rx_data,
  input  logic                  bu_rx_data_rdy,
  input  logic                  rd_en,
  output logic [7:0]            rxb_data,
  output logic                  rxb_data_vld,
  output logic [DEPTH_LOG2:0]   rxb_count,
  output logic                  rxb_full,
  output logic                  rxb_line_rdy,
  output logic                  rxb_overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [7:0]            CR_BYTE  = 8'h0D;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         lines_q, lines_d;
  logic                  overflow_q, overflow_d;
  logic                  is_esc, push, pop, drop, full, inc_line, dec_line;
  logic [7:0]            head;

`ifdef RXB_ESC_FILTER_EN
  assign is_esc = (bu_rx_data == 8'h1B);
`else
  assign is_esc = 1'b0;
`endif

  // Handshake: the producer strobe has no back-pressure (a byte offered while full
  // with no pop is lost and flagged); the consumer pops on rd_en && rxb_data_vld.
  assign full     = (count_q == CNT_FULL);
  assign head     = mem_q[rd_ptr_q];
  assign pop      = !rst && rd_en && (count_q != '0);
  assign push     = !rst && bu_rx_data_rdy && !is_esc && (!full || pop);
  assign drop     = !rst && bu_rx_data_rdy && !is_esc && full && !pop;
  assign inc_line = push && (bu_rx_data == CR_BYTE);
  assign dec_line = pop && (head == CR_BYTE);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lines_d    = lines_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    case ({inc_line, dec_line})
      2'b10:   lines_d = lines_q + CNT_ONE;
      2'b01:   lines_d = lines_q - CNT_ONE;
      default: lines_d = lines_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lines_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lines_q    <= lines_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; validity is tracked solely by the count and pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bu_rx_data;
  end

  assign rxb_data_vld = (count_q != '0);
  assign rxb_data     = rxb_data_vld ? head : 8'h00;
  assign rxb_count    = count_q;
  assign rxb_full     = full;
  assign rxb_line_rdy = (lines_q != '0);
  assign rxb_overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_line_buf.sv
// Self-checking bench for uart_rx_line_buf: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_uart_rx_line_buf;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bu_rx_data = 8'h00;
  logic       bu_rx_data_rdy = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rxb_data;
  logic       rxb_data_vld;
  logic [4:0] rxb_count;
  logic       rxb_full;
  logic       rxb_line_rdy;
  logic       rxb_overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  uart_rx_line_buf #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .bu_rx_data(bu_rx_data), .bu_rx_data_rdy(bu_rx_data_rdy), .rd_en(rd_en),
    .rxb_data(rxb_data), .rxb_data_vld(rxb_data_vld), .rxb_count(rxb_count),
    .rxb_full(rxb_full), .rxb_line_rdy(rxb_line_rdy), .rxb_overflow(rxb_overflow)
  );

  always #5 clk = ~clk;

  function automatic bit filtered(input logic [7:0] b);
`ifdef RXB_ESC_FILTER_EN
    return (b == 8'h1B);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int cr = 0;
    foreach (exp_q[i]) if (exp_q[i] == 8'h0D) cr++;
    chk("count",    32'(rxb_count),    32'(exp_q.size()));
    chk("vld",      32'(rxb_data_vld), 32'(exp_q.size() != 0));
    chk("data",     32'(rxb_data),     32'(exp_q.size() != 0 ? exp_q[0] : 8'h00));
    chk("full",     32'(rxb_full),     32'(exp_q.size() == 16));
    chk("line_rdy", 32'(rxb_line_rdy), 32'(cr != 0));
    chk("overflow", 32'(rxb_overflow), 32'(exp_ovf));
  endtask

  // One clock cycle: drive, advance the model at the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic [7:0] d, input logic p, input logic rs);
    bit popped;
    rst = rs; bu_rx_data_rdy = r; bu_rx_data = d; rd_en = p;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      popped = p && (exp_q.size() != 0);
      if (r && !filtered(d) && exp_q.size() == 16 && !popped) exp_ovf = 1'b1;
      if (popped) void'(exp_q.pop_front());
      if (r && !filtered(d) && (exp_q.size() < 16)) exp_q.push_back(d);
    end
    #1;
    rst = 1'b0; bu_rx_data_rdy = 1'b0; rd_en = 1'b0;
    check_model();
  endtask

  initial begin
    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_count", 32'(rxb_count), 32'd0);
    chk("rst_data",  32'(rxb_data),  32'd0);

    // Simple line: 'A','B',CR then three pops
    step(1'b1, 8'h41, 1'b0, 1'b0);
    chk("lat_vld", 32'(rxb_data_vld), 32'd1);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h0D, 1'b0, 1'b0);
    chk("line_count", 32'(rxb_count), 32'd3);
    chk("line_rdy",   32'(rxb_line_rdy), 32'd1);
    chk("line_head",  32'(rxb_data), 32'h41);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop1", 32'(rxb_data), 32'h42);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop2", 32'(rxb_data), 32'h0D);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("line_gone", 32'(rxb_line_rdy), 32'd0);
    chk("empty_vld", 32'(rxb_data_vld), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);  // pop while empty

    // Overflow: 17 writes, then drain 16
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("ovf_full",  32'(rxb_full), 32'd1);
    chk("ovf_count", 32'(rxb_count), 32'd16);
    chk("ovf_flag",  32'(rxb_overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_order", 32'(rxb_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("ovf_sticky", 32'(rxb_overflow), 32'd1);

    // Full with simultaneous write and pop
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullrw_count", 32'(rxb_count), 32'd16);
    chk("fullrw_ovf",   32'(rxb_overflow), 32'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullrw_last", 32'(rxb_data), 32'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming at occupancy 3 across pointer wrap
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 3; i < 40; i++) begin
      chk("stream_head", 32'(rxb_data), 32'(8'hC0 + i - 3));
      step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
      chk("stream_occ", 32'(rxb_count), 32'd3);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Escape byte handling
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h1B, 1'b0, 1'b0);
`ifdef RXB_ESC_FILTER_EN
    chk("esc_count", 32'(rxb_count), 32'd0);
`else
    chk("esc_count", 32'(rxb_count), 32'd1);
    chk("esc_data",  32'(rxb_data), 32'h1B);
`endif

    // Reset mid-operation with coincident write
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h0D, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("mrst_count", 32'(rxb_count), 32'd0);
    chk("mrst_vld",   32'(rxb_data_vld), 32'd0);
    chk("mrst_data",  32'(rxb_data), 32'd0);
    chk("mrst_ovf",   32'(rxb_overflow), 32'd0);
    chk("mrst_line",  32'(rxb_line_rdy), 32'd0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      case ($urandom_range(0, 5))
        0: d = 8'h0D;
        1: d = 8'h1B;
        default: d = 8'($urandom_range(0, 255));
      endcase
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) == 0 ? 1 : 0),
           1'($urandom_range(0, 149) == 0 ? 1 : 0));
    end
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
